bit_scan_iter: RTL and testbench

Sequential set-bit iterator that sits directly downstream of the bit get/set/clear logic. It accepts a bit vector over a valid/ready handshake and emits the index of every set bit, one per transfer, on a valid/ready output stream. Each emitted bit is removed from an internal working copy, using the same clear-bit operation, `in & ~(1 << pos)`. Typical consumers are request/grant and free-list logic that must service every set flag exactly once.

---
 rtl/bit_scan_pkg.sv | 15 +
 rtl/bit_prio_enc.sv | 26 ++
 rtl/bit_scan_iter.sv | 109 ++++++++++
 tb/tb_bit_scan_iter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_scan_pkg.sv
// Shared types and helpers for the bit_scan_iter set-bit iterator.
package bit_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // True when at most one bit of v is set; callers zero-extend narrower vectors.
    function automatic logic onehot_or_zero(input logic [255:0] v);
        return (v & (v - 256'd1)) == 256'd0;
    endfunction

endpackage

// File: rtl/bit_prio_enc.sv
// Combinational priority encoder; BITSCAN_MSB_FIRST_EN selects the highest set bit,
// otherwise the lowest set bit wins.
module bit_prio_enc #(
    parameter  int NUM_INPUT = 8,
    localparam int POS_W     = $clog2(NUM_INPUT)
) (
    input  logic [NUM_INPUT-1:0] vec_i,
    output logic [POS_W-1:0]     idx_o,
    output logic                 found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = |vec_i;
`ifdef BITSCAN_MSB_FIRST_EN
        for (int i = 0; i < NUM_INPUT; i++) begin
            if (vec_i[i]) idx_o = POS_W'(i);
        end
`else
        for (int i = NUM_INPUT - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = POS_W'(i);
        end
`endif
    end

endmodule

// File: rtl/bit_scan_iter.sv
// Set-bit iterator: loads a vector, streams out each set-bit index once, then pulses done.
// Scan direction follows BITSCAN_MSB_FIRST_EN (see bit_prio_enc).
module bit_scan_iter
    import bit_scan_pkg::*;
#(
    parameter  int NUM_INPUT = 8,
    localparam int POS_W     = $clog2(NUM_INPUT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [NUM_INPUT-1:0] load_vec,
    output logic                 pos_valid,
    input  logic                 pos_ready,
    output logic [POS_W-1:0]     pos,
    output logic                 pos_last,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [POS_W:0]       count
);

    localparam logic [NUM_INPUT-1:0] ONE     = {{(NUM_INPUT-1){1'b0}}, 1'b1};
    localparam logic [POS_W:0]       CNT_ONE = {{POS_W{1'b0}}, 1'b1};

    scan_state_t          state_q, state_d;
    logic [NUM_INPUT-1:0] work_q, work_d;
    logic [POS_W:0]       cnt_q, cnt_d;
    logic [POS_W:0]       count_q, count_d;
    logic [POS_W-1:0]     enc_idx;
    logic                 enc_found;
    logic                 last_bit;

    bit_prio_enc #(.NUM_INPUT(NUM_INPUT)) u_enc (
        .vec_i   (work_q),
        .idx_o   (enc_idx),
        .found_o (enc_found)
    );

    assign last_bit = enc_found & onehot_or_zero(256'(work_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    // Abort overrides any load or transfer; count only changes on entry to DONE.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        if (abort) begin
            state_d = IDLE;
            work_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        work_d = load_vec;
                        cnt_d  = '0;
                        if (|load_vec) begin
                            state_d = EMIT;
                        end else begin
                            state_d = DONE;
                            count_d = '0;
                        end
                    end
                end
                EMIT: begin
                    if (pos_ready) begin
                        work_d = work_q & ~(ONE << enc_idx);
                        cnt_d  = cnt_q + CNT_ONE;
                        if (last_bit) begin
                            state_d = DONE;
                            count_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        load_ready = (state_q == IDLE);
        pos_valid  = (state_q == EMIT);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        pos_last   = (state_q == EMIT) & last_bit;
        pos        = enc_idx;
        count      = count_q;
    end

endmodule

// File: tb/tb_bit_scan_iter.sv
// Directed self-checking bench for bit_scan_iter with NUM_INPUT=8; honours BITSCAN_MSB_FIRST_EN.
module tb_bit_scan_iter;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_vec;
    logic       pos_valid;
    logic       pos_ready;
    logic [2:0] pos;
    logic       pos_last;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] count;

    int passed;
    int total;

    bit_scan_iter #(.NUM_INPUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_vec   (load_vec),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .pos        (pos),
        .pos_last   (pos_last),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready got %b want 1", load_ready); else passed++;
        total++; if (pos_valid !== 1'b0) $display("FAIL reset_pos_valid got %b want 0", pos_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        total++; if (pos !== 3'd0) $display("FAIL reset_pos got %0d want 0", pos); else passed++;
    endtask

    task automatic test_scan_order();
        logic [2:0] exp_pos [3];
`ifdef BITSCAN_MSB_FIRST_EN
        exp_pos = '{3'd7, 3'd5, 3'd2};
`else
        exp_pos = '{3'd2, 3'd5, 3'd7};
`endif
        pos_ready  = 1'b1;
        load_vec   = 8'b1010_0100;
        load_valid = 1'b1;
        total++; if (load_ready !== 1'b1) $display("FAIL scan_load_ready got %b want 1", load_ready); else passed++;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (pos_valid !== 1'b1) $display("FAIL scan_pos_valid[%0d] got %b want 1", i, pos_valid); else passed++;
            total++; if (pos !== exp_pos[i]) $display("FAIL scan_pos[%0d] got %0d want %0d", i, pos, exp_pos[i]); else passed++;
            total++; if (pos_last !== (i == 2)) $display("FAIL scan_last[%0d] got %b want %b", i, pos_last, (i == 2)); else passed++;
            total++; if (load_ready !== 1'b0) $display("FAIL scan_load_ready_emit[%0d] got %b want 0", i, load_ready); else passed++;
            tick();
        end
        total++; if (done !== 1'b1) $display("FAIL scan_done got %b want 1", done); else passed++;
        total++; if (count !== 4'd3) $display("FAIL scan_count got %0d want 3", count); else passed++;
        total++; if (pos_valid !== 1'b0) $display("FAIL scan_pos_valid_done got %b want 0", pos_valid); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL scan_done_pulse got %b want 0", done); else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL scan_ready_back got %b want 1", load_ready); else passed++;
        total++; if (count !== 4'd3) $display("FAIL scan_count_hold got %0d want 3", count); else passed++;
    endtask

    task automatic test_zero_vector();
        load_vec   = 8'h00;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        total++; if (pos_valid !== 1'b0) $display("FAIL zero_pos_valid got %b want 0", pos_valid); else passed++;
        total++; if (done !== 1'b1) $display("FAIL zero_done got %b want 1", done); else passed++;
        total++; if (count !== 4'd0) $display("FAIL zero_count got %0d want 0", count); else passed++;
        total++; if (load_ready !== 1'b0) $display("FAIL zero_load_ready_n1 got %b want 0", load_ready); else passed++;
        tick();
        total++; if (load_ready !== 1'b1) $display("FAIL zero_load_ready_n2 got %b want 1", load_ready); else passed++;
        total++; if (pos_valid !== 1'b0) $display("FAIL zero_pos_valid_n2 got %b want 0", pos_valid); else passed++;
    endtask

    task automatic test_backpressure();
        logic [2:0] first_pos;
        logic [2:0] second_pos;
`ifdef BITSCAN_MSB_FIRST_EN
        first_pos = 3'd7; second_pos = 3'd0;
`else
        first_pos = 3'd0; second_pos = 3'd7;
`endif
        pos_ready  = 1'b0;
        load_vec   = 8'h81;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (pos_valid !== 1'b1) $display("FAIL bp_pos_valid[%0d] got %b want 1", i, pos_valid); else passed++;
            total++; if (pos !== first_pos) $display("FAIL bp_pos_hold[%0d] got %0d want %0d", i, pos, first_pos); else passed++;
            total++; if (pos_last !== 1'b0) $display("FAIL bp_last_hold[%0d] got %b want 0", i, pos_last); else passed++;
            tick();
        end
        pos_ready = 1'b1;
        total++; if (pos !== first_pos) $display("FAIL bp_pos_first got %0d want %0d", pos, first_pos); else passed++;
        tick();
        total++; if (pos !== second_pos) $display("FAIL bp_pos_second got %0d want %0d", pos, second_pos); else passed++;
        total++; if (pos_last !== 1'b1) $display("FAIL bp_last_second got %b want 1", pos_last); else passed++;
        tick();
        total++; if (done !== 1'b1) $display("FAIL bp_done got %b want 1", done); else passed++;
        total++; if (count !== 4'd2) $display("FAIL bp_count got %0d want 2", count); else passed++;
        tick();
    endtask

    task automatic test_abort();
        logic [2:0] exp;
        pos_ready  = 1'b1;
        load_vec   = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
`ifdef BITSCAN_MSB_FIRST_EN
            exp = 3'(7 - i);
`else
            exp = 3'(i);
`endif
            total++; if (pos !== exp) $display("FAIL abort_pos[%0d] got %0d want %0d", i, pos, exp); else passed++;
            tick();
        end
        abort      = 1'b1;
        load_valid = 1'b1;
        load_vec   = 8'h10;
        tick();
        abort      = 1'b0;
        load_valid = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else passed++;
        total++; if (pos_valid !== 1'b0) $display("FAIL abort_pos_valid got %b want 0", pos_valid); else passed++;
        total++; if (count !== 4'd2) $display("FAIL abort_count got %0d want 2", count); else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL abort_load_ready got %b want 1", load_ready); else passed++;
        load_vec   = 8'h10;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        total++; if (pos !== 3'd4) $display("FAIL abort_reload_pos got %0d want 4", pos); else passed++;
        total++; if (pos_last !== 1'b1) $display("FAIL abort_reload_last got %b want 1", pos_last); else passed++;
        tick();
        total++; if (done !== 1'b1) $display("FAIL abort_reload_done got %b want 1", done); else passed++;
        total++; if (count !== 4'd1) $display("FAIL abort_reload_count got %0d want 1", count); else passed++;
        tick();
    endtask

    task automatic test_full_vector();
        pos_ready  = 1'b1;
        load_vec   = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (pos_last !== (i == 7)) $display("FAIL full_last[%0d] got %b want %b", i, pos_last, (i == 7)); else passed++;
            tick();
        end
        total++; if (done !== 1'b1) $display("FAIL full_done got %b want 1", done); else passed++;
        total++; if (count !== 4'd8) $display("FAIL full_count got %0d want 8", count); else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        pos_ready  = 1'b0;
        load_vec   = 8'h0F;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        total++; if (pos_valid !== 1'b1) $display("FAIL areset_pre_pos_valid got %b want 1", pos_valid); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (pos_valid !== 1'b0) $display("FAIL areset_pos_valid got %b want 0", pos_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL areset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL areset_done got %b want 0", done); else passed++;
        total++; if (count !== 4'd0) $display("FAIL areset_count got %0d want 0", count); else passed++;
        #2;
        rst_n = 1'b1;
        tick();
        total++; if (load_ready !== 1'b1) $display("FAIL areset_load_ready got %b want 1", load_ready); else passed++;
        total++; if (pos_valid !== 1'b0) $display("FAIL areset_post_pos_valid got %b want 0", pos_valid); else passed++;
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_vec   = 8'h00;
        pos_ready  = 1'b0;
        abort      = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_scan_order();
        test_zero_vector();
        test_backpressure();
        test_abort();
        test_full_vector();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
